// File: rtl/guess_entry.sv
// Guess entry: steps a 6-bit guess up/down through an external adder and
// offers it downstream with a valid/ready hold. GUESS_WRAP_EN selects wrap instead of saturation.
module guess_entry #(
  parameter int unsigned STEP_FAST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       fast,
  input  logic       clear,
  input  logic       submit,
  output logic [5:0] op_a,
  output logic [5:0] op_b,
  output logic       add_cin,
  input  logic [5:0] sum,
  input  logic       cout,
  output logic [5:0] guess,
  output logic       busy,
  output logic       guess_valid,
  input  logic       guess_ready
);

  localparam int unsigned W = 6;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [W-1:0] GUESS_MAX = {W{1'b1}};
  localparam logic [W-1:0] STEP_F = W'(STEP_FAST);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] guess_q, guess_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic         cin_q, cin_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic [W-1:0] step_c;
  logic         range_err_c;

  // add_cin doubles as the direction flag: 0 = increment, 1 = decrement
  assign step_c      = fast ? STEP_F : W'(1);
  assign range_err_c = cin_q ? ~cout : cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      guess_q <= '0;
      op_b_q  <= '0;
      cin_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      op_b_q  <= op_b_d;
      cin_q   <= cin_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    guess_d = guess_q;
    op_b_d  = op_b_q;
    cin_d   = cin_q;
    unique case (state_q)
      IDLE: begin
        if (submit) begin
          state_d = HOLD;
        end else if (clear) begin
          guess_d = '0;
        end else if (inc ^ dec) begin
          op_b_d  = inc ? step_c : ~step_c;
          cin_d   = dec;
          state_d = ADD;
        end
      end
      ADD: begin
        state_d = IDLE;
        guess_d = sum;
`ifndef GUESS_WRAP_EN
        if (range_err_c) guess_d = cin_q ? '0 : GUESS_MAX;
`endif
      end
      HOLD: begin
        if (guess_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == ADD);
    valid_d = (state_d == HOLD);
  end

`ifdef GUESS_WRAP_EN
  logic unused_c;
  assign unused_c = range_err_c;
`endif

  assign op_a        = guess_q;
  assign op_b        = op_b_q;
  assign add_cin     = cin_q;
  assign guess       = guess_q;
  assign busy        = busy_q;
  assign guess_valid = valid_q;

endmodule

// File: tb/tb_guess_entry.sv
// Scoreboarded random + directed bench for guess_entry with an external adder model.
module tb_guess_entry;

  localparam int STEP = 8;
`ifdef GUESS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc = 1'b0, dec = 1'b0, fast = 1'b0, clear = 1'b0, submit = 1'b0;
  logic       guess_ready = 1'b0;
  logic [5:0] op_a, op_b, sum, guess;
  logic       add_cin, cout, busy, guess_valid;

  guess_entry #(.STEP_FAST(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .fast(fast), .clear(clear),
    .submit(submit), .op_a(op_a), .op_b(op_b), .add_cin(add_cin), .sum(sum),
    .cout(cout), .guess(guess), .busy(busy), .guess_valid(guess_valid),
    .guess_ready(guess_ready)
  );

  // external adder
  assign {cout, sum} = 7'(op_a) + 7'(op_b) + 7'(add_cin);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tgt;
    int g;
    int b;
    int v;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // reference model: guess value, pending result, and whether busy / holding
  int m_guess = 0, m_pend = 0;
  bit m_busy = 0, m_hold = 0;

  function automatic int apply(input int g, input bit up, input int s);
    int v;
    v = up ? g + s : g - s;
    if (v > 63) v = WRAP ? v - 64 : 63;
    if (v < 0)  v = WRAP ? v + 64 : 0;
    return v;
  endfunction

  task automatic model_edge(input bit i, input bit d, input bit f, input bit c,
                            input bit s, input bit r);
    if (m_busy) begin
      m_guess = m_pend;
      m_busy  = 0;
    end else if (m_hold) begin
      if (r) m_hold = 0;
    end else if (s) begin
      m_hold = 1;
    end else if (c) begin
      m_guess = 0;
    end else if (i != d) begin
      m_pend = apply(m_guess, i, f ? STEP : 1);
      m_busy = 1;
    end
  endtask

  // one clock of stimulus; optional async reset pulse before driving
  task automatic step(input bit i, input bit d, input bit f, input bit c,
                      input bit s, input bit r, input bit pr);
    @(posedge clk);
    #1;
    if (pr) begin
      rst_n = 1'b0;
      #2;
      chk("rst_guess", int'(guess), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(guess_valid), 0);
      chk("rst_op_b", int'(op_b), 0);
      chk("rst_cin", int'(add_cin), 0);
      sb.delete();
      m_guess = 0; m_busy = 0; m_hold = 0;
      #1;
      rst_n = 1'b1;
    end
    inc = i; dec = d; fast = f; clear = c; submit = s; guess_ready = r;
    model_edge(i, d, f, c, s, r);
    sb.push_back('{cyc + 1, m_guess, int'(m_busy), int'(m_hold)});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_now(input string name, input int req);
    @(negedge clk);
    chk(name, int'(guess), req);
  endtask

  task automatic set_guess(input int v);
    int rem;
    rem = v;
    step(0, 0, 0, 1, 0, 0, 0);
    while (rem >= STEP) begin
      step(1, 0, 1, 0, 0, 0, 0); idle(1);
      rem -= STEP;
    end
    while (rem > 0) begin
      step(1, 0, 0, 0, 0, 0, 0); idle(1);
      rem -= 1;
    end
    idle(1);
  endtask

  // monitor: compares DUT outputs against queued expectations each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].tgt == cyc) begin
        e = sb.pop_front();
        chk("guess", int'(guess), e.g);
        chk("op_a", int'(op_a), e.g);
        chk("busy", int'(busy), e.b);
        chk("guess_valid", int'(guess_valid), e.v);
      end
    end
  end

  initial begin
    #12;
    chk("reset_guess", int'(guess), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(guess_valid), 0);
    chk("reset_op_b", int'(op_b), 0);
    chk("reset_cin", int'(add_cin), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // three slow increments from reset
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 0, 0); idle(1);
    end
    idle(1);
    check_now("inc_x3", 3);

    set_guess(60);
    step(1, 0, 1, 0, 0, 0, 0); idle(2);
    check_now("inc_fast_top", WRAP ? 4 : 63);

    set_guess(5);
    step(0, 1, 1, 0, 0, 0, 0); idle(2);
    check_now("dec_fast_bottom", WRAP ? 61 : 0);

    set_guess(5);
    step(0, 1, 0, 0, 0, 0, 0); idle(2);
    check_now("dec_slow", 4);

    step(1, 1, 0, 0, 0, 0, 0); idle(2);
    check_now("inc_dec_same", 4);

    step(1, 0, 0, 0, 0, 0, 0); step(1, 0, 1, 0, 0, 0, 0); idle(2);
    check_now("inc_during_add", 5);

    set_guess(9);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    idle(1);
    @(negedge clk);
    chk("hold_valid", int'(guess_valid), 1);
    chk("hold_guess", int'(guess), 9);
    step(0, 0, 0, 0, 0, 1, 0); idle(1);
    @(negedge clk);
    chk("release_valid", int'(guess_valid), 0);

    // reset during ADD; first post-release pulse must be honoured
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(3);
    check_now("no_late_update", 0);
    step(1, 0, 1, 0, 0, 0, 1);
    idle(2);
    check_now("first_after_reset", STEP);

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 30,
           $urandom_range(1, 0) == 1, $urandom_range(99, 0) < 4,
           $urandom_range(99, 0) < 5, $urandom_range(99, 0) < 40,
           $urandom_range(999, 0) < 4);
    end
    idle(2);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
